eth_mac_tx_framer: RTL and testbench

Byte-wide Ethernet transmit framer between the TX FIFO (AXI-Stream bytes) and the RGMII DDR output stage. It accepts one packet per AXI-Stream transaction and emits a complete GMII-style byte stream: preamble, SFD, payload, optional zero padding, FCS, and inter-frame gap. The RGMII stage serialises `gmii_txd` into nibbles on `rgmii_phy_txd` and drives `gmii_txen ^ gmii_txer` onto `rgmii_phy_txctl`.

---
 rtl/eth_mac_pkg.sv | 13 +
 rtl/crc32_byte.sv | 16 +
 rtl/eth_mac_tx_framer.sv | 140 ++++++++++++++
 tb/tb_eth_mac_tx_framer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_mac_pkg.sv
// Shared constants and the TX framer state type for the Ethernet MAC blocks.
package eth_mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_DRAIN, S_IFG
  } tx_state_t;

endpackage

// File: rtl/crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB first); purely combinational.
module crc32_byte
  import eth_mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
  end

endmodule

// File: rtl/eth_mac_tx_framer.sv
// Byte-wide Ethernet TX framer: preamble/SFD, payload, optional pad, FCS, IFG.
// Define TX_MAC_PAD_EN to zero-pad short frames up to MIN_FRAME_BYTES.
module eth_mac_tx_framer
  import eth_mac_pkg::*;
#(
  parameter int IFG_BYTES       = 12,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic       clk_125,
  input  logic       reset_n,
  input  logic [7:0] s_tx_axis_tdata,
  input  logic       s_tx_axis_tvalid,
  input  logic       s_tx_axis_tlast,
  output logic       s_tx_axis_trdy,
  output logic [7:0] gmii_txd,
  output logic       gmii_txen,
  output logic       gmii_txer
);

  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

  tx_state_t   r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [31:0] r_crc, w_crc_nxt, w_crc_upd, w_fcs;
  logic [7:0]  r_txd, w_txd_nxt, w_crc_data;
  logic        r_txen, r_txer, w_txen_nxt, w_txer_nxt;
  logic        w_trdy, w_short;

  assign w_trdy    = (r_state == S_SFD) || (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_fcs     = ~r_crc;

`ifdef TX_MAC_PAD_EN
  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
  // w_cnt_inc is the length including the byte being accepted now
  assign w_short    = (w_cnt_inc < MIN_LEN);
  assign w_crc_data = (r_state == S_PAD) ? 8'h00 : s_tx_axis_tdata;
`else
  assign w_short    = 1'b0;
  assign w_crc_data = s_tx_axis_tdata;
`endif

  crc32_byte u_crc (.crc_in(r_crc), .data(w_crc_data), .crc_out(w_crc_upd));

  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_crc   <= CRC_INIT;
      r_txd   <= '0;
      r_txen  <= 1'b0;
      r_txer  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_crc   <= w_crc_nxt;
      r_txd   <= w_txd_nxt;
      r_txen  <= w_txen_nxt;
      r_txer  <= w_txer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (s_tx_axis_tvalid) w_state_nxt = S_PREAMBLE;
      S_PREAMBLE: if (r_cnt == 16'd7) w_state_nxt = S_SFD;
      S_SFD, S_PAYLOAD: begin
        if (!s_tx_axis_tvalid)    w_state_nxt = S_DRAIN;
        else if (s_tx_axis_tlast) w_state_nxt = w_short ? S_PAD : S_FCS;
        else                      w_state_nxt = S_PAYLOAD;
      end
`ifdef TX_MAC_PAD_EN
      S_PAD:      if (w_cnt_inc == MIN_LEN) w_state_nxt = S_FCS;
`endif
      S_FCS:      if (r_cnt == 16'd3) w_state_nxt = S_IFG;
      S_DRAIN:    if (s_tx_axis_tvalid && s_tx_axis_tlast) w_state_nxt = S_IFG;
      S_IFG:      if (r_cnt == IFG_LAST) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_txd_nxt  = 8'h00;
    w_txen_nxt = 1'b0;
    w_txer_nxt = 1'b0;
    w_cnt_nxt  = r_cnt;
    w_crc_nxt  = r_crc;
    case (r_state)
      S_IDLE: if (s_tx_axis_tvalid) begin
        w_txd_nxt  = PREAMBLE_BYTE;
        w_txen_nxt = 1'b1;
        w_cnt_nxt  = 16'd1;
      end
      S_PREAMBLE: begin
        w_txen_nxt = 1'b1;
        if (r_cnt == 16'd7) begin
          w_txd_nxt = SFD_BYTE;
          w_cnt_nxt = '0;
          w_crc_nxt = CRC_INIT;
        end else begin
          w_txd_nxt = PREAMBLE_BYTE;
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_SFD, S_PAYLOAD: begin
        w_txen_nxt = 1'b1;
        if (s_tx_axis_tvalid) begin
          w_txd_nxt = s_tx_axis_tdata;
          w_crc_nxt = w_crc_upd;
          w_cnt_nxt = (s_tx_axis_tlast && !w_short) ? 16'd0 : w_cnt_inc;
        end else begin
          // underrun: flag the frame as bad and abandon it
          w_txer_nxt = 1'b1;
          w_cnt_nxt  = '0;
        end
      end
`ifdef TX_MAC_PAD_EN
      S_PAD: begin
        w_txen_nxt = 1'b1;
        w_crc_nxt  = w_crc_upd;
        w_cnt_nxt  = (w_cnt_inc == MIN_LEN) ? 16'd0 : w_cnt_inc;
      end
`endif
      S_FCS: begin
        w_txen_nxt = 1'b1;
        w_txd_nxt  = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
        w_cnt_nxt  = (r_cnt == 16'd3) ? 16'd0 : r_cnt + 16'd1;
      end
      S_IFG:   w_cnt_nxt = (r_cnt == IFG_LAST) ? 16'd0 : r_cnt + 16'd1;
      default: ;
    endcase
  end

  assign s_tx_axis_trdy = w_trdy;
  assign gmii_txd       = r_txd;
  assign gmii_txen      = r_txen;
  assign gmii_txer      = r_txer;

endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// Randomized bench for eth_mac_tx_framer against a frame-level reference model.
module tb_eth_mac_tx_framer;

  localparam int IFG  = 12;
  localparam int MINF = 60;
`ifdef TX_MAC_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic       clk_125 = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tdata   = '0;
  logic       tvalid  = 1'b0;
  logic       tlast   = 1'b0;
  logic       trdy;
  logic [7:0] txd;
  logic       txen, txer;

  always #4 clk_125 = ~clk_125;

  eth_mac_tx_framer #(.IFG_BYTES(IFG), .MIN_FRAME_BYTES(MINF)) dut (
    .clk_125(clk_125), .reset_n(reset_n),
    .s_tx_axis_tdata(tdata), .s_tx_axis_tvalid(tvalid), .s_tx_axis_tlast(tlast),
    .s_tx_axis_trdy(trdy),
    .gmii_txd(txd), .gmii_txen(txen), .gmii_txer(txer)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // monitor: split the GMII stream into frames (txen runs) and record the gap before each
  byte unsigned cur_b[$], fb[$], got_b[$];
  bit          cur_e[$], fe[$], got_e[$];
  int          fl[$], gap_q[$];
  bit          gtr_q[$];

  initial begin
    int gap; bit gtr, inf;
    gap = 0; gtr = 0; inf = 0;
    forever begin
      @(negedge clk_125);
      if (!reset_n) begin
        cur_b.delete(); cur_e.delete(); inf = 0; gap = 0; gtr = 0;
      end else if (txen) begin
        if (!inf) begin gap_q.push_back(gap); gtr_q.push_back(gtr); end
        inf = 1; gap = 0; gtr = 0;
        cur_b.push_back(txd); cur_e.push_back(txer);
      end else begin
        if (inf) begin
          fl.push_back(cur_b.size());
          foreach (cur_b[i]) begin fb.push_back(cur_b[i]); fe.push_back(cur_e[i]); end
          cur_b.delete(); cur_e.delete(); inf = 0;
        end
        gap++;
        if (trdy) gtr = 1;
      end
    end
  end

  // reference model: bit-serial reflected CRC-32 and frame layout
  byte unsigned pkt[$], exp_b[$];

  function automatic logic [31:0] fcs_ref(input byte unsigned d[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (d[i])
      for (int b = 0; b < 8; b++) begin
        bit fb_bit = c[0] ^ d[i][b];
        c = c >> 1;
        if (fb_bit) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  // bub >= 0: frame aborted after bub payload bytes with one error byte
  task automatic build_exp(input int bub);
    byte unsigned body[$];
    logic [31:0] f;
    exp_b.delete();
    repeat (7) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    if (bub >= 0) begin
      for (int i = 0; i < bub; i++) exp_b.push_back(pkt[i]);
      exp_b.push_back(8'h00);
      return;
    end
    body = pkt;
    if (PAD) while (body.size() < MINF) body.push_back(8'h00);
    foreach (body[i]) exp_b.push_back(body[i]);
    f = fcs_ref(body);
    for (int k = 0; k < 4; k++) exp_b.push_back(f[8*k +: 8]);
  endtask

  task automatic rand_pkt(input int len);
    pkt.delete();
    repeat (len) pkt.push_back(8'($urandom));
  endtask

  // drive pkt; optional one-cycle tvalid bubble after 'bub' accepts; return after 'stop' accepts
  task automatic send_pkt(input int bub, input int stop);
    int i = 0, cyc = 0, len = pkt.size();
    bit t, bubbled = 0;
    tvalid = 1; tdata = pkt[0]; tlast = (len == 1);
    while (i < len) begin
      @(negedge clk_125); t = trdy;
      @(posedge clk_125); cyc++;
      if (t && tvalid) i++;
      #1;
      if (i == stop) return;
      if (i == bub && !bubbled && i < len) begin
        tvalid = 0; bubbled = 1;
      end else if (i < len) begin
        tvalid = 1; tdata = pkt[i]; tlast = (i == len - 1);
      end
      if (cyc > 4000) begin chk("send_timeout", i, len); return; end
    end
  endtask

  task automatic idle_in(input int n);
    tvalid = 0; tlast = 0;
    repeat (n) @(posedge clk_125);
    #1;
  endtask

  task automatic check_frame(input string tag, input int er_at);
    int w = 0, n, nerr = 0, first_bad = 0;
    while (fl.size() == 0 && w < 3000) begin @(negedge clk_125); w++; end
    if (fl.size() == 0) begin chk({tag, "_timeout"}, fl.size(), 1); return; end
    n = fl.pop_front();
    got_b.delete(); got_e.delete();
    repeat (n) begin got_b.push_back(fb.pop_front()); got_e.push_back(fe.pop_front()); end
    chk({tag, "_len"}, n, exp_b.size());
    first_bad = failures;
    for (int i = 0; i < n && i < exp_b.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), got_b[i], exp_b[i]);
      if (failures != first_bad) break;
    end
    foreach (got_e[i]) if (got_e[i] != (i == er_at)) nerr++;
    chk({tag, "_txer"}, nerr, 0);
  endtask

  initial begin
    byte unsigned e1[$], e2[$];
    int len, bub;

    repeat (3) @(posedge clk_125);
    #1;
    chk("rst_txen", txen, 0);
    chk("rst_txer", txer, 0);
    chk("rst_txd",  txd,  0);
    chk("rst_trdy", trdy, 0);
    reset_n = 1;
    idle_in(2);

    // known-answer frame: "123456789"
    pkt.delete();
    for (int i = 0; i < 9; i++) pkt.push_back(8'(8'h31 + i));
    build_exp(-1);
    send_pkt(-1, -1); idle_in(0);
    check_frame("ascii9", -1);
    if (!PAD) begin
      chk("ascii9_ncyc", got_b.size(), 21);
      chk("ascii9_fcs", {got_b[17], got_b[18], got_b[19], got_b[20]}, 32'h2639F4CB);
    end else
      chk("ascii9_ncyc", got_b.size(), 72);
    idle_in(20);

    // single-byte packet
    pkt.delete(); pkt.push_back(8'hA5);
    build_exp(-1);
    send_pkt(-1, -1); idle_in(0);
    check_frame("one", -1);
    chk("one_ncyc", got_b.size(), PAD ? 72 : 13);
    idle_in(20);

    // back-to-back 64-byte packets with tvalid held high
    rand_pkt(64); build_exp(-1); e1 = exp_b; e2 = pkt;
    gap_q.delete(); gtr_q.delete();
    send_pkt(-1, -1);
    rand_pkt(64); e2 = pkt; build_exp(-1); e2 = exp_b;
    send_pkt(-1, -1); idle_in(0);
    exp_b = e1; check_frame("b2b0", -1);
    exp_b = e2; check_frame("b2b1", -1);
    chk("b2b_nframes", gap_q.size(), 2);
    if (gap_q.size() >= 2) begin
      chk("b2b_gap", gap_q[1], IFG);
      chk("b2b_gap_trdy", gtr_q[1], 0);
    end
    idle_in(20);

    // underrun after payload byte 5
    rand_pkt(20); build_exp(5);
    send_pkt(5, -1); idle_in(0);
    check_frame("urun5", 13);
    idle_in(20);

    // asynchronous reset in the middle of the payload
    rand_pkt(30);
    send_pkt(-1, 5);
    #2 reset_n = 0;
    #1;
    chk("mrst_txen", txen, 0);
    chk("mrst_txer", txer, 0);
    chk("mrst_trdy", trdy, 0);
    tvalid = 0; tlast = 0;
    repeat (2) @(posedge clk_125);
    #1 reset_n = 1;
    idle_in(2);
    chk("mrst_noframe", fl.size(), 0);
    rand_pkt(17); build_exp(-1);
    send_pkt(-1, -1); idle_in(0);
    check_frame("after_rst", -1);
    idle_in(5);

    // randomized packets, some with an underrun at a random position
    for (int n = 0; n < 20; n++) begin
      len = $urandom_range(1, 100);
      bub = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
      rand_pkt(len); build_exp(bub);
      send_pkt(bub, -1); idle_in(0);
      check_frame($sformatf("rnd%0d", n), (bub >= 0) ? bub + 8 : -1);
      idle_in($urandom_range(0, 5));
    end

    idle_in(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
